ro_power_monitor: RTL and testbench

Parametrised, clocked controller for a ring-oscillator power-sensor array. It gates the RO counters for a programmable measurement window, waits for the counts to settle, and sums the enabled channels serially into one wide result. Each result is delivered over a valid/ready handshake, in single-shot or continuous mode. It sits between the RO_counter array and the trace-capture logic, and replaces the free-running, enable-edge-sampled adder-tree monitor.

---
 rtl/ro_power_monitor.sv | 195 +++++++++++++++++++
 tb/tb_ro_power_monitor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_power_monitor.sv
// ro_power_monitor
// Sequences one ring-oscillator power measurement. It clears the RO counters,
// gates them for a fixed window, waits for the counts to settle, then adds the
// enabled channels one per cycle into a wide result. The result is handed out
// over a valid/ready handshake. After the handshake the block either returns
// to idle (single-shot) or starts the next window straight away (continuous).
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for i_start
//   S_CLEAR  | one cycle: clear RO counters, latch mask, zero accumulator
//   S_RUN    | o_ro_en high for WINDOW_CYCLES cycles
//   S_SETTLE | o_ro_en low for SETTLE_CYCLES cycles while RO counts settle
//   S_SUM    | add one channel per cycle, index 0..OSC_CNT-1
//   S_OUT    | result presented; held until o_out_valid & i_out_ready
//
// Ports
//   i_clk, i_reset         system clock, asynchronous active-high reset
//   i_start                begin a measurement (only honoured in idle)
//   i_continuous           restart automatically after each accepted result
//   i_osc_mask             per-channel include mask, captured in S_CLEAR
//   i_ro_count             packed RO counts, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   o_ro_en, o_ro_clr      enable / synchronous-clear to the RO counters
//   o_out_valid/i_out_ready result handshake
//   o_out_sum, o_out_wrap, o_out_id  result payload
//   o_busy                 high whenever the controller is not idle
module ro_power_monitor #(
  parameter int OSC_CNT       = 16,
  parameter int CNT_WIDTH     = 32,
  parameter int WINDOW_CYCLES = 256,
  parameter int SETTLE_CYCLES = 4,
  parameter int SUM_WIDTH     = CNT_WIDTH + $clog2(OSC_CNT)
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic                           i_continuous,
  input  logic [OSC_CNT-1:0]             i_osc_mask,
  input  logic [OSC_CNT*CNT_WIDTH-1:0]   i_ro_count,
  output logic                           o_ro_en,
  output logic                           o_ro_clr,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [SUM_WIDTH-1:0]           o_out_sum,
  output logic                           o_out_wrap,
  output logic [15:0]                    o_out_id,
  output logic                           o_busy
);

  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_W   = $clog2(OSC_CNT);

  localparam logic [TMR_W-1:0] WIN_LOAD = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] SET_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OSC_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_SUM,
    S_OUT
  } state_t;

  state_t                r_state;
  logic [TMR_W-1:0]      r_tmr;
  logic [IDX_W-1:0]      r_idx;
  logic [OSC_CNT-1:0]    r_mask;
  logic [SUM_WIDTH-1:0]  r_acc;
  logic                  r_wrap;
  logic [15:0]           r_id_cnt;
  logic                  r_ro_en;
  logic                  r_out_valid;
  logic [SUM_WIDTH-1:0]  r_out_sum;
  logic                  r_out_wrap;
  logic [15:0]           r_out_id;
  logic                  r_busy;

  logic [CNT_WIDTH-1:0]  w_chan;
  logic                  w_chan_en;
  logic [SUM_WIDTH-1:0]  w_addend;
  logic [SUM_WIDTH-1:0]  w_acc_next;
  logic                  w_wrap_next;

  // Channel select as a compare-per-channel mux; avoids a variable-width
  // multiply in the part-select index.
  always_comb begin
    w_chan = '0;
    for (int i = 0; i < OSC_CNT; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_chan = i_ro_count[i*CNT_WIDTH +: CNT_WIDTH];
      end
    end
  end

  assign w_chan_en   = r_mask[r_idx];
  assign w_addend    = w_chan_en ? SUM_WIDTH'(w_chan) : '0;
  assign w_acc_next  = r_acc + w_addend;
  // An enabled counter sitting at all-ones may have wrapped during the window.
  assign w_wrap_next = r_wrap | (w_chan_en & (&w_chan));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_idx       <= '0;
      r_mask      <= '0;
      r_acc       <= '0;
      r_wrap      <= 1'b0;
      r_id_cnt    <= '0;
      r_ro_en     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_wrap  <= 1'b0;
      r_out_id    <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_mask  <= i_osc_mask;
          r_acc   <= '0;
          r_wrap  <= 1'b0;
          r_idx   <= '0;
          r_tmr   <= WIN_LOAD;
          r_ro_en <= 1'b1;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_tmr == '0) begin
            r_ro_en <= 1'b0;
            r_tmr   <= SET_LOAD;
            r_state <= S_SETTLE;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        S_SETTLE: begin
          if (r_tmr == '0) begin
            r_idx   <= '0;
            r_state <= S_SUM;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        S_SUM: begin
          r_acc  <= w_acc_next;
          r_wrap <= w_wrap_next;
          if (r_idx == IDX_LAST) begin
            r_out_sum   <= w_acc_next;
            r_out_wrap  <= w_wrap_next;
            r_out_id    <= r_id_cnt;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_OUT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_id_cnt    <= r_id_cnt + 16'd1;
            if (i_continuous) begin
              r_state <= S_CLEAR;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Counters are held cleared for the whole of reset as well as in S_CLEAR.
  assign o_ro_clr    = i_reset | (r_state == S_CLEAR);
  assign o_ro_en     = r_ro_en;
  assign o_out_valid = r_out_valid;
  assign o_out_sum   = r_out_sum;
  assign o_out_wrap  = r_out_wrap;
  assign o_out_id    = r_out_id;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_ro_power_monitor.sv
// Testbench for ro_power_monitor at default parameters. Stimulus pushes the
// expected result into a queue; an independent monitor pops and compares on
// every handshake. Timing, hold and boundary behaviour is checked inline.
module tb_ro_power_monitor;

  localparam int N  = 16;
  localparam int CW = 32;
  localparam int SW = 36;
  localparam int LAT = 277;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              continuous;
  logic [N-1:0]      osc_mask;
  logic [N*CW-1:0]   ro_count;
  logic              ro_en;
  logic              ro_clr;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     out_sum;
  logic              out_wrap;
  logic [15:0]       out_id;
  logic              busy;

  ro_power_monitor dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_continuous (continuous),
    .i_osc_mask   (osc_mask),
    .i_ro_count   (ro_count),
    .o_ro_en      (ro_en),
    .o_ro_clr     (ro_clr),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_sum    (out_sum),
    .o_out_wrap   (out_wrap),
    .o_out_id     (out_id),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sum;
    logic          wrap;
    logic [15:0]   id;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pushes   = 0;
  int   results  = 0;
  logic [15:0] exp_id = 16'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input logic [SW-1:0] s, input logic w);
    exp_t e;
    e.sum  = s;
    e.wrap = w;
    e.id   = exp_id;
    q.push_back(e);
    exp_id = exp_id + 16'd1;
    pushes++;
  endtask

  task automatic set_seq_counts();
    for (int i = 0; i < N; i++) ro_count[i*CW +: CW] = 32'(1000 + i);
  endtask

  task automatic set_all_counts(input logic [CW-1:0] v);
    for (int i = 0; i < N; i++) ro_count[i*CW +: CW] = v;
  endtask

  // Pulses start (sampled at E0) and waits for out_valid; n is the edge index
  // at which out_valid was first seen. Optional extra start pulses at ign1/ign2.
  task automatic start_wait(output int n, output int en_cnt, output int clr_cnt,
                            input int ign1, input int ign2);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    en_cnt  = int'(ro_en);
    clr_cnt = int'(ro_clr);
    while (!out_valid && n < 1000) begin
      start = (n == ign1 || n == ign2);
      @(posedge clk); #1 start = 1'b0;
      n++;
      en_cnt  += int'(ro_en);
      clr_cnt += int'(ro_clr);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (out_valid && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("handshake_timeout", 64'(k < 1000), 64'd1);
  endtask

  task automatic run_single(input string nm, input logic [N-1:0] m,
                            input logic [SW-1:0] s, input logic w);
    int n, e, c;
    osc_mask = m;
    push_exp(s, w);
    start_wait(n, e, c, -1, -1);
    chk({nm, "_latency"}, 64'(n), 64'(LAT));
    wait_done();
    chk({nm, "_busy_fall"}, 64'(busy), 64'd0);
  endtask

  // Scoreboard monitor: one compare per handshake edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && !reset) begin
        results++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual_id=%0h required=none", out_id);
        end else begin
          e = q.pop_front();
          chk("result_sum",  64'(out_sum),  64'(e.sum));
          chk("result_wrap", 64'(out_wrap), 64'(e.wrap));
          chk("result_id",   64'(out_id),   64'(e.id));
        end
      end
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, en_cnt, clr_cnt, extra, bad_sum, bad_id, bad_en, bad_valid;
    logic [15:0] id_bp;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; out_ready = 1'b1;
    osc_mask = '1;
    set_seq_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ro_en",  64'(ro_en),     64'd0);
    chk("rst_ro_clr", 64'(ro_clr),    64'd1);
    chk("rst_valid",  64'(out_valid), 64'd0);
    chk("rst_sum",    64'(out_sum),   64'd0);
    chk("rst_wrap",   64'(out_wrap),  64'd0);
    chk("rst_id",     64'(out_id),    64'd0);
    chk("rst_busy",   64'(busy),      64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single shot, all channels, timing of ro_en/ro_clr
    osc_mask = 16'hFFFF;
    push_exp(36'd16120, 1'b0);
    start_wait(n, en_cnt, clr_cnt, -1, -1);
    chk("s1_latency", 64'(n), 64'(LAT));
    chk("s1_ro_en_cycles", 64'(en_cnt), 64'd256);
    chk("s1_ro_clr_cycles", 64'(clr_cnt), 64'd1);
    wait_done();
    chk("s1_busy_fall", 64'(busy), 64'd0);

    run_single("mask_00ff", 16'h00FF, 36'd8028, 1'b0);
    run_single("mask_0000", 16'h0000, 36'd0, 1'b0);

    set_all_counts(32'hFFFF_FFFF);
    run_single("all_ones", 16'hFFFF, 36'hF_FFFF_FFF0, 1'b1);
    run_single("ones_ch3_off", 16'hFFF7, 36'hE_FFFF_FFF1, 1'b1);
    set_all_counts(32'd5);
    ro_count[3*CW +: CW] = 32'hFFFF_FFFF;
    run_single("only_ch3_ones_off", 16'hFFF7, 36'd75, 1'b0);

    // Start pulses in RUN, SUM and OUT must be ignored
    set_seq_counts();
    osc_mask = 16'hFFFF;
    out_ready = 1'b0;
    push_exp(36'd16120, 1'b0);
    start_wait(n, en_cnt, clr_cnt, 100, 270);
    chk("ign_latency", 64'(n), 64'(LAT));
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done();
    extra = 0;
    repeat (300) begin
      @(posedge clk); #1;
      extra += int'(out_valid);
    end
    chk("ign_no_extra_result", 64'(extra), 64'd0);
    chk("ign_idle", 64'(busy), 64'd0);

    // Continuous with back-pressure
    out_ready  = 1'b0;
    continuous = 1'b1;
    id_bp = exp_id;
    push_exp(36'd16120, 1'b0);
    start_wait(n, en_cnt, clr_cnt, -1, -1);
    chk("bp_latency", 64'(n), 64'(LAT));
    bad_sum = 0; bad_id = 0; bad_en = 0; bad_valid = 0;
    repeat (50) begin
      @(posedge clk); #1;
      bad_sum   += int'(out_sum != 36'd16120);
      bad_id    += int'(out_id != id_bp);
      bad_en    += int'(ro_en);
      bad_valid += int'(!out_valid);
    end
    chk("bp_sum_held", 64'(bad_sum), 64'd0);
    chk("bp_id_held", 64'(bad_id), 64'd0);
    chk("bp_ro_en_low", 64'(bad_en), 64'd0);
    chk("bp_valid_held", 64'(bad_valid), 64'd0);
    push_exp(36'd16120, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("cont_clear_next", 64'(ro_clr), 64'd1);
    chk("cont_busy", 64'(busy), 64'd1);
    chk("cont_valid_drop", 64'(out_valid), 64'd0);
    n = 0;
    while (!out_valid && n < 1000) begin
      if (n == 100) continuous = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("cont_period_latency", 64'(n), 64'(LAT));
    chk("cont_id_next", 64'(out_id), 64'(id_bp + 16'd1));
    @(posedge clk); #1;
    chk("cont_drop_busy", 64'(busy), 64'd0);
    chk("cont_drop_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of RUN
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (99) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ro_en", 64'(ro_en), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ro_clr", 64'(ro_clr), 64'd1);
    chk("mid_rst_id", 64'(out_id), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    exp_id = 16'd0;
    @(posedge clk); #1 reset = 1'b0;
    run_single("after_rst", 16'hFFFF, 36'd16120, 1'b0);

    repeat (5) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("result_count", 64'(results), 64'(pushes));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
